// File: rtl/uart_rx_stream_if.sv
// Received-word stream between uart_rx_stream and its consumer.
// Signals:
//   out_data   received data word
//   out_valid  out_data and err_* valid, held until out_ready
//   out_ready  consumer accepts on out_valid && out_ready
//   err_frame  a stop bit was sampled 0
//   err_parity parity mismatch (0 when parity is disabled)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_stream_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err_frame;
    logic                 err_parity;

    modport master (
        output out_data,
        output out_valid,
        output err_frame,
        output err_parity,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  err_frame,
        input  err_parity,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: oversampling UART receiver with valid/ready output register,
// per-frame error sideband and overrun detection. Runs on clk with an internal
// baud-tick divider; no derived clocks.
// Optional feature macro: UART_RX_BREAK_EN (line-break detection, BREAK state).
// The CLK_HZ/BAUD defaults mirror the system clock/baud rate definitions.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   enabled      0 = synchronous clear to IDLE, frame in progress dropped
//   in           asynchronous rx line, idle high
//   stream       master side of uart_rx_stream_if (data, valid/ready, errors)
//   busy         frame in progress (START..STOP)
//   err_overrun  1-clk pulse: completed frame dropped because output was full
//   break_det    1-clk pulse on line break (0 unless UART_RX_BREAK_EN)
module uart_rx_stream #(
    parameter int unsigned CLK_HZ      = 1_600_000,
    parameter int unsigned BAUD        = 10_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enabled,
    input  logic                    in,
    uart_rx_stream_if.master        stream,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    break_det
);

    localparam int unsigned DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned SAMP_A = OVERSAMPLE / 2 - 1;
    localparam int unsigned SAMP_B = OVERSAMPLE / 2;
    localparam int unsigned SAMP_C = OVERSAMPLE / 2 + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [1:0]             r_samp;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_busy;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_acc;
    logic                   r_perr_acc;
    logic                   r_ferr_acc;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_perr;
    logic                   r_overrun;
    logic                   w_rx;
    logic                   w_fall;
    logic                   w_start;
    logic                   w_tick;
    logic                   w_mid_done;
    logic                   w_bit;
    logic                   w_complete;
    logic                   w_break;

    // Rx line synchroniser; idles high so reset does not look like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], in};
            r_rx_prev <= w_rx;
        end
    end

    assign w_rx    = r_sync[SYNC_STAGES-1];
    // A 1->0 transition is required, so a line held low never restarts a frame
    assign w_fall  = r_rx_prev & ~w_rx;
    assign w_start = (r_state == S_IDLE) && w_fall;
    assign w_tick  = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_mid_done = w_tick && (r_tick_cnt == TICK_W'(SAMP_C));
    // Majority vote of the two stored samples and the live third sample
    assign w_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);

    // Baud divider and per-bit tick counter, both re-phased on the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_samp     <= '0;
        end else if (!enabled || w_start) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == TICK_W'(OVERSAMPLE - 1)) ? '0
                                                                       : r_tick_cnt + TICK_W'(1);
                if (r_tick_cnt == TICK_W'(SAMP_A)) r_samp[0] <= w_rx;
                if (r_tick_cnt == TICK_W'(SAMP_B)) r_samp[1] <= w_rx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_START) || (w_state_nxt == S_DATA) ||
                       (w_state_nxt == S_PARITY) || (w_state_nxt == S_STOP);
        end
    end

`ifdef UART_RX_BREAK_EN
    logic r_all_zero;
    logic r_break;

    // Tracks whether every bit of the current frame has been sampled 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_zero <= 1'b0;
            r_break    <= 1'b0;
        end else if (!enabled) begin
            r_all_zero <= 1'b0;
            r_break    <= 1'b0;
        end else begin
            r_break <= w_break;
            if (w_start) begin
                r_all_zero <= 1'b1;
            end else if (w_mid_done && (r_state == S_DATA || r_state == S_PARITY ||
                                        r_state == S_STOP)) begin
                r_all_zero <= r_all_zero & ~w_bit;
            end
        end
    end

    assign break_det = r_break;
`else
    assign break_det = 1'b0;
`endif

    // Next-state logic; bit decisions happen at the last mid-bit sample
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_break     = 1'b0;
        if (!enabled) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) w_state_nxt = S_START;
                end
                S_START: begin
                    if (w_mid_done) w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_mid_done && (r_bit_cnt == BIT_W'(DATA_BITS - 1)))
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (w_mid_done) w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    // Completes at the mid-sample so a back-to-back start edge is seen
                    if (w_mid_done && (r_stop_cnt == 1'(STOP_BITS - 1))) begin
`ifdef UART_RX_BREAK_EN
                        if (r_all_zero && !w_bit) begin
                            w_state_nxt = S_BREAK;
                            w_break     = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_complete  = 1'b1;
                        end
`else
                        w_state_nxt = S_IDLE;
                        w_complete  = 1'b1;
`endif
                    end
                end
`ifdef UART_RX_BREAK_EN
                S_BREAK: begin
                    if (w_rx) w_state_nxt = S_IDLE;
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame assembly: data shift, parity and stop checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else if (!enabled || w_start) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_acc  <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else if (w_mid_done) begin
            case (r_state)
                S_DATA: begin
                    r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_par_acc <= r_par_acc ^ w_bit;
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
                S_PARITY: begin
                    // Odd parity wants XOR(data,parity)=1, even wants 0
                    r_perr_acc <= (PARITY == 1) ? ~(r_par_acc ^ w_bit) : (r_par_acc ^ w_bit);
                end
                S_STOP: begin
                    r_ferr_acc <= r_ferr_acc | ~w_bit;
                    r_stop_cnt <= r_stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output register with valid/ready handshake and overrun detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!enabled) begin
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_valid || stream.out_ready) begin
                    r_data  <= r_shift;
                    r_ferr  <= r_ferr_acc | ~w_bit;
                    r_perr  <= r_perr_acc;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && stream.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign stream.out_data   = r_data;
    assign stream.out_valid  = r_valid;
    assign stream.err_frame  = r_ferr;
    assign stream.err_parity = r_perr;
    assign busy              = r_busy;
    assign err_overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream, 8 data bits, even parity, 1 stop bit,
// 1.6 MHz clock at 10 kbaud x16 (160 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_stream;

    localparam int unsigned DB       = 8;
    localparam int unsigned BIT_CLKS = 160;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic enabled  = 1'b0;
    logic line     = 1'b1;
    logic busy;
    logic err_overrun;
    logic break_det;

    uart_rx_stream_if #(.DATA_BITS(DB)) u_if ();

    uart_rx_stream #(
        .CLK_HZ     (1_600_000),
        .BAUD       (10_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (DB),
        .PARITY     (2),
        .STOP_BITS  (1),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enabled    (enabled),
        .in         (line),
        .stream     (u_if),
        .busy       (busy),
        .err_overrun(err_overrun),
        .break_det  (break_det)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ovr_seen  = 0;
    int   brk_seen  = 0;
    int   exp_ovr   = 0;
    int   exp_brk   = 0;
    bit   rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: even parity means XOR(data, parity bit) must be 0
    function automatic exp_t model(input logic [DB-1:0] d, input logic pbit, input logic sbit);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ pbit;
        e.ferr = ~sbit;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_overrun) ovr_seen++;
            if (break_det)   brk_seen++;
            if (u_if.out_valid && u_if.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", u_if.out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data",   32'(u_if.out_data),   32'(e.data));
                    check("err_parity", 32'(u_if.err_parity), 32'(e.perr));
                    check("err_frame",  32'(u_if.err_frame),  32'(e.ferr));
                end
            end
        end
    end

    // Random back-pressure, applied away from the active edge
    always @(posedge clk) begin
        #2;
        if (rnd_ready) u_if.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        line = v;
        repeat (BIT_CLKS) step();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic sbit);
        drive_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(sbit);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic send_push(input logic [DB-1:0] d, input logic pbit, input logic sbit);
        sb.push_back(model(d, pbit, sbit));
        send_frame(d, pbit, sbit);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            step();
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        logic [DB-1:0] d;
        logic          pb;
        logic          stp;

        u_if.out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid",   32'(u_if.out_valid),  32'd0);
        check("rst_out_data",    32'(u_if.out_data),   32'd0);
        check("rst_err_frame",   32'(u_if.err_frame),  32'd0);
        check("rst_err_parity",  32'(u_if.err_parity), 32'd0);
        check("rst_err_overrun", 32'(err_overrun),     32'd0);
        check("rst_break_det",   32'(break_det),       32'd0);
        check("rst_busy",        32'(busy),            32'd0);

        rst_n   = 1'b1;
        enabled = 1'b1;
        repeat (20) step();

        // Clean frame, parity error, framing error
        send_push(8'hA5, ^8'hA5, 1'b1);
        drain();
        send_push(8'h03, 1'b1, 1'b1);
        drain();
        send_push(8'h55, ^8'h55, 1'b0);
        drain();

        // Overrun: first word held, second dropped
        u_if.out_ready = 1'b0;
        send_push(8'h11, ^8'h11, 1'b1);
        exp_ovr++;
        send_frame(8'h22, ^8'h22, 1'b1);
        check("ovr_hold_valid", 32'(u_if.out_valid), 32'd1);
        check("ovr_hold_data",  32'(u_if.out_data),  32'h11);
        check("ovr_pulses",     32'(ovr_seen),       32'(exp_ovr));
        u_if.out_ready = 1'b1;
        drain();

        // Short low glitch on the start bit
        line = 1'b0;
        repeat (30) step();
        check("glitch_busy_up", 32'(busy), 32'd1);
        line = 1'b1;
        repeat (120) step();
        check("glitch_busy_down", 32'(busy), 32'd0);
        repeat (BIT_CLKS) step();
        send_push(8'h3C, ^8'h3C, 1'b1);
        drain();

        // Randomised frames with random parity/stop faults and back-pressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            d   = 8'($urandom);
            pb  = (^d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 3) != 0);
            send_push(d, pb, stp);
        end
        drain();
        rnd_ready = 1'b0;
        step();
        u_if.out_ready = 1'b1;

        // Disable during data bit 3
        d = 8'($urandom);
        line = 1'b0;
        repeat (BIT_CLKS) step();
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        line = d[3];
        repeat (BIT_CLKS / 2) step();
        check("dis_busy_before", 32'(busy), 32'd1);
        enabled = 1'b0;
        step();
        check("dis_busy_after",  32'(busy),           32'd0);
        check("dis_out_valid",   32'(u_if.out_valid), 32'd0);
        line = 1'b1;
        repeat (12 * BIT_CLKS) step();
        enabled = 1'b1;
        repeat (BIT_CLKS) step();

        // Line held low for 12 bit times
`ifdef UART_RX_BREAK_EN
        exp_brk = 1;
`else
        sb.push_back(model(8'h00, 1'b0, 1'b0));
`endif
        line = 1'b0;
        repeat (12 * BIT_CLKS) step();
        line = 1'b1;
        repeat (3 * BIT_CLKS) step();
        drain();
        check("break_pulses", 32'(brk_seen), 32'(exp_brk));

        // Recovery after the break
        send_push(8'h5A, ^8'h5A, 1'b1);
        drain();
        check("ovr_total", 32'(ovr_seen), 32'(exp_ovr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
